// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the 16-bit SRAM memory-stage controller.
// Holds the FSM state encoding, the parameter defaults and the phase address helper.
package sram_ctrl_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Defaults for the controller parameters
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;
  localparam int          DEF_WAIT_CYCLES = 2;

  // Halfword address of one phase of a word access. The byte offset from the base
  // wraps mod 2^32, addr[1:0] is dropped, and hi selects the upper halfword.
  // The caller truncates the result to the SRAM address width.
  function automatic logic [31:0] phase_addr(input logic [31:0] byte_addr,
                                             input logic [31:0] base,
                                             input logic        hi);
    return (((byte_addr - base) >> 2) << 1) | {31'd0, hi};
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: per-phase wait counter for the SRAM controller.
// Loaded on entry to each SRAM phase and counts down to zero. last_cycle
// flags the final cycle of the phase, which is when read data is sampled.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;

  logic [CW-1:0] count;

  // Reload on phase entry, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign last_cycle = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: memory-stage controller that performs 32-bit loads/stores as two
// 16-bit SRAM phases (low half, then high half), each WAIT_CYCLES long.
// ready=0 freezes the pipeline until the access completes.
// Optional feature: define SRAM_CTRL_WBUF_EN for posted writes, where a store
// is accepted immediately and drained in the background without a DONE cycle.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_en,
  input  logic               mem_write_en,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_wdata,
  input  logic [15:0]        sram_rdata,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

`ifdef SRAM_CTRL_WBUF_EN
  localparam logic POSTED_WRITES = 1'b1;
`else
  localparam logic POSTED_WRITES = 1'b0;
`endif

  logic [1:0]  state;
  logic        op_write;
  logic [15:0] wdata_hi;
  logic        req;
  logic        load;
  logic        last_cycle;
  logic [1:0]  hi_next;

  assign req = mem_read_en | mem_write_en;

  // Counter restarts when a request starts the low phase and when low hands over to high
  assign load = ((state == ST_IDLE) && req) || ((state == ST_LO) && last_cycle);

  // Posted writes return straight to IDLE; everything else reports completion in DONE
  assign hi_next = (POSTED_WRITES && op_write) ? ST_IDLE : ST_DONE;

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .last_cycle (last_cycle)
  );

  // Access sequencer: latch the request, run the two halfword phases, then complete
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_write   <= 1'b0;
      wdata_hi   <= '0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            // Write wins when both enables are set
            state      <= ST_LO;
            op_write   <= mem_write_en;
            wdata_hi   <= wdata[31:16];
            sram_addr  <= SRAM_AW'(phase_addr(addr, BASE_ADDR, 1'b0));
            sram_wdata <= wdata[15:0];
            sram_we_n  <= ~mem_write_en;
            sram_oe_n  <= mem_write_en;
          end
        end
        ST_LO: begin
          if (last_cycle) begin
            if (!op_write) begin
              rdata[15:0] <= sram_rdata;
            end
            state      <= ST_HI;
            sram_addr  <= {sram_addr[SRAM_AW-1:1], 1'b1};
            sram_wdata <= wdata_hi;
          end
        end
        ST_HI: begin
          if (last_cycle) begin
            if (!op_write) begin
              rdata[31:16] <= sram_rdata;
            end
            state     <= hi_next;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline stall: idle without a request (or a postable write), a background drain
  // with nothing waiting behind it, or the single completion cycle
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE:      ready = ~req | (POSTED_WRITES & mem_write_en);
      ST_LO, ST_HI: ready = POSTED_WRITES & op_write & ~req;
      default:      ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: self-checking bench for sram_ctrl. Directed accesses, a reset
// in the middle of a write, then randomized loads/stores checked against a
// halfword-array reference model, stall-length rules and SRAM address order.
module tb_sram_ctrl;

  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'd1024;
  localparam int          AW    = 18;
  localparam int          DEPTH = 1 << AW;
  localparam int          WORDS = 1 << (AW - 1);

`ifdef SRAM_CTRL_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_read_en = 1'b0;
  logic          mem_write_en = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wdata;
  logic [15:0]   sram_rdata;
  logic          sram_we_n;
  logic          sram_oe_n;

  int checks = 0;
  int failures = 0;
  bit last_posted = 1'b0;
  bit mem_clear = 1'b1;
  int txn_no = 0;

  logic [15:0]   sram_mem [0:DEPTH-1];
  logic [15:0]   ref_mem  [0:DEPTH-1];
  int unsigned   touched [$];
  logic [AW-1:0] seen [$];

  always #5 clk = ~clk;

  sram_ctrl #(
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (W),
    .SRAM_AW     (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .ready        (ready),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n)
  );

  // External SRAM model: cleared at start, written on clock edges while we_n is low
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) sram_mem[i] <= 16'h0000;
    end else if (!sram_we_n) begin
      sram_mem[sram_addr] <= sram_wdata;
    end
  end

  assign sram_rdata = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Halfword index of the low half of the word holding byte address a
  function automatic int unsigned ref_hw(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return ((off / 4) % WORDS) * 2;
  endfunction

  // One pipeline memory instruction: optional idle gap, then hold the request until ready
  task automatic run_txn(input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input int gap);
    int unsigned hw;
    int          stall;
    int          exp_stall;
    int          drain_rem;
    bit          posted;
    bit          got_ready;
    hw        = ref_hw(a);
    posted    = WBUF && wr;
    drain_rem = 0;
    if (last_posted && (2 * W - gap) > 0) drain_rem = 2 * W - gap;
    exp_stall = drain_rem + (posted ? 0 : 1 + 2 * W);

    @(posedge clk); #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    mem_read_en  = rd;
    mem_write_en = wr;
    addr         = a;
    wdata        = d;

    seen.delete();
    stall     = 0;
    got_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!sram_we_n || !sram_oe_n) seen.push_back(sram_addr);
      if (ready) begin
        got_ready = 1'b1;
        break;
      end
      stall++;
    end
    check_eq("ready_seen", 32'(got_ready), 32'd1);
    check_eq("stall_len", stall, exp_stall);

    if (!wr) begin
      check_eq("rdata", rdata, {ref_mem[hw + 1], ref_mem[hw]});
    end else begin
      ref_mem[hw]     = d[15:0];
      ref_mem[hw + 1] = d[31:16];
      touched.push_back(hw);
      if (!posted) begin
        check_eq("sram_lo", 32'(sram_mem[hw]), 32'(d[15:0]));
        check_eq("sram_hi", 32'(sram_mem[hw + 1]), 32'(d[31:16]));
      end
    end

    if (!last_posted && !posted) begin
      check_eq("phase_cnt", seen.size(), 2 * W);
      if (seen.size() > 0) begin
        check_eq("phase_first", 32'(seen[0]), hw);
        check_eq("phase_last", 32'(seen[seen.size() - 1]), hw + 1);
      end
    end

    $display("txn %0d %s addr=0x%08h hw=0x%05h data=0x%08h stall=%0d",
             txn_no, wr ? "WR" : "RD", a, hw, wr ? d : rdata, stall);
    txn_no++;
    last_posted = posted;
  endtask

  initial begin
    logic [AW-1:0] hi_addr;
    int unsigned   hw;
    bit            found;
    int            op;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;

    // Reset and idle
    repeat (3) @(posedge clk);
    mem_clear = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    check_eq("rst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_sram_addr", 32'(sram_addr), 32'd0);
    check_eq("rst_sram_wdata", 32'(sram_wdata), 32'd0);

    // Directed accesses
    run_txn(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 0);
    run_txn(1'b0, 1'b1, 32'd1024, 32'h0, 0);
    run_txn(1'b0, 1'b1, 32'd1032, 32'h0, 0);
    run_txn(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 1);
    run_txn(1'b0, 1'b1, 32'd1032, 32'h0, 0);
    run_txn(1'b1, 1'b0, 32'd0, 32'hA5A55A5A, 2);
    run_txn(1'b0, 1'b1, 32'd3, 32'h0, 0);

    // Reset asserted during the high phase of a write: only the low half lands
    @(posedge clk); #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    repeat (2 * W + 2) @(posedge clk);
    #1;
    hw           = ref_hw(32'd1040);
    hi_addr      = AW'(hw + 1);
    mem_write_en = 1'b1;
    addr         = 32'd1040;
    wdata        = 32'h12345678;
    found        = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!sram_we_n && sram_addr == hi_addr) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_hi_phase", 32'(found), 32'd1);
    rst          = 1'b1;
    mem_write_en = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_ready", 32'(ready), 32'd1);
    check_eq("midrst_we_n", 32'(sram_we_n), 32'd1);
    check_eq("midrst_oe_n", 32'(sram_oe_n), 32'd1);
    check_eq("midrst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_mem[hw] = 16'h5678;
    touched.push_back(hw);
    last_posted = 1'b0;
    run_txn(1'b0, 1'b1, 32'd1040, 32'h0, 0);

    // Randomized loads and stores over a small window
    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 2));
      run_txn(op != 0, op != 1,
              BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3)),
              $urandom, int'($urandom_range(0, 5)));
    end

    // Let any background drain finish, then sweep every written word
    @(posedge clk); #1;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    repeat (2 * W + 3) @(posedge clk);
    #1;
    foreach (touched[i]) begin
      check_eq("final_lo", 32'(sram_mem[touched[i]]), 32'(ref_mem[touched[i]]));
      check_eq("final_hi", 32'(sram_mem[touched[i] + 1]), 32'(ref_mem[touched[i] + 1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
